mem_arbiter: RTL

Single-port memory arbiter sharing the CPU's unified memory between three requesters: VGA scanout (real-time reads), the instruction fetch unit, and the data path (AGU-addressed loads/stores). It sits between those requesters and the synchronous-read memory macro. It grants at most one access per cycle:
- VGA has strict priority, backed by a starvation guard.
- Fetch and data share round-robin.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: VGA scanout has strict priority behind a starvation
// guard, instruction fetch and data path share the remaining slots round-robin.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 14,
   parameter int DATA_WIDTH   = 16,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                  clk,
   input  logic                  rst_async,
   input  logic                  vga_req,
   input  logic [ADDR_WIDTH-1:0] vga_addr,
   output logic                  vga_gnt,
   output logic                  vga_rdata_valid,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_gnt,
   output logic                  fetch_rdata_valid,
   input  logic                  data_req,
   input  logic                  data_we,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_wdata,
   output logic                  data_gnt,
   output logic                  data_rdata_valid,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);

   logic          r_rr_last;     // 0: fetch won last CPU grant, 1: data won
   logic [CW-1:0] r_starve_cnt;
   logic          r_vga_valid;
   logic          r_fetch_valid;
   logic          r_data_valid;

   logic w_cpu_pending;
   logic w_starved;
   logic w_vga_gnt;
   logic w_fetch_gnt;
   logic w_data_gnt;

   assign w_cpu_pending = fetch_req | data_req;
   assign w_starved     = w_cpu_pending & (r_starve_cnt == C_LIMIT);

   always_comb begin
      w_vga_gnt   = 1'b0;
      w_fetch_gnt = 1'b0;
      w_data_gnt  = 1'b0;
      if (!rst_async) begin
         if (vga_req && !w_starved) begin
            w_vga_gnt = 1'b1;
         end else if (fetch_req && data_req) begin
            // Tie goes to whichever CPU requester did not win last time.
            w_fetch_gnt = r_rr_last;
            w_data_gnt  = ~r_rr_last;
         end else begin
            w_fetch_gnt = fetch_req;
            w_data_gnt  = data_req;
         end
      end
   end

   always_comb begin
      mem_addr = vga_addr;
      if (w_fetch_gnt) begin
         mem_addr = fetch_addr;
      end else if (w_data_gnt) begin
         mem_addr = data_addr;
      end
   end

   assign vga_gnt   = w_vga_gnt;
   assign fetch_gnt = w_fetch_gnt;
   assign data_gnt  = w_data_gnt;
   assign mem_we    = w_data_gnt & data_we;
   assign mem_wdata = data_wdata;
   assign rdata     = mem_rdata;

   assign vga_rdata_valid   = r_vga_valid;
   assign fetch_rdata_valid = r_fetch_valid;
   assign data_rdata_valid  = r_data_valid;

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_rr_last <= 1'b0;
      end else if (w_fetch_gnt) begin
         r_rr_last <= 1'b0;
      end else if (w_data_gnt) begin
         r_rr_last <= 1'b1;
      end
   end

   // Counts consecutive cycles a pending CPU request has lost to VGA.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_starve_cnt <= '0;
      end else if (w_fetch_gnt || w_data_gnt || !w_cpu_pending) begin
         r_starve_cnt <= '0;
      end else if (w_vga_gnt && (r_starve_cnt != C_LIMIT)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         r_vga_valid   <= 1'b0;
         r_fetch_valid <= 1'b0;
         r_data_valid  <= 1'b0;
      end else begin
         r_vga_valid   <= w_vga_gnt;
         r_fetch_valid <= w_fetch_gnt;
         r_data_valid  <= w_data_gnt & ~data_we;
      end
   end

endmodule
